// File: rtl/i2s_tdm_clk_gen.sv
// Master-mode I2S/TDM frame sequencer: divides mclk into bclk and generates lrclk, with frame-aligned start/stop.
// Define I2S_TDM_CLKGEN_FRAME_COUNT_EN to add the 16-bit frame_count output.
module i2s_tdm_clk_gen #(
    parameter int NR_CHANNELS      = 4,
    parameter int SLOT_WIDTH       = 32,
    parameter int MCLK_BCLK_RATIO  = 4,
    parameter bit LRCLK_POLARITY   = 1'b1,
    parameter bit FRAME_SYNC_PULSE = 1'b1
) (
    input  logic                           mclk,
    input  logic                           rst,
    input  logic                           en,
    output logic                           busy,
    output logic                           bclk,
    output logic                           lrclk,
    output logic                           frame_start,
    output logic [$clog2(NR_CHANNELS)-1:0] slot
`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
    ,
    output logic [15:0]                    frame_count
`endif
);

    localparam int DIV_W  = $clog2(MCLK_BCLK_RATIO);
    localparam int BIT_W  = $clog2(SLOT_WIDTH);
    localparam int SLOT_W = $clog2(NR_CHANNELS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MCLK_BCLK_RATIO - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(MCLK_BCLK_RATIO / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NR_CHANNELS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(NR_CHANNELS / 2);

    localparam bit PARAMS_BAD = (NR_CHANNELS < 2) || (SLOT_WIDTH < 8) ||
                                (MCLK_BCLK_RATIO < 2) || (MCLK_BCLK_RATIO % 2 != 0) ||
                                (!FRAME_SYNC_PULSE && (NR_CHANNELS % 2 != 0));

    generate
        if (PARAMS_BAD) begin : g_param_check
            $fatal(1, "i2s_tdm_clk_gen: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                busy_q, busy_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_end;
    logic                active_d;
    logic                in_sync_d;

    assign frame_end = (div_q == DIV_LAST) && (bit_q == BIT_LAST) && (slot_q == SLOT_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        slot_d  = slot_q;

        unique case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                bit_d  = '0;
                slot_d = '0;
                if (en) state_d = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                // Counters wrap to zero at frame end, which is both the next frame's start and the idle value.
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d  = '0;
                        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end

                if (frame_end) state_d = en ? ST_RUN : ST_IDLE;
                else           state_d = en ? ST_RUN : ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase

        active_d = (state_d != ST_IDLE);

        if (FRAME_SYNC_PULSE) in_sync_d = (slot_d == '0) && (bit_d == '0);
        else                  in_sync_d = (slot_d < SLOT_HALF);

        bclk_d        = active_d && (div_d >= DIV_HALF);
        lrclk_d       = (active_d && in_sync_d) ? LRCLK_POLARITY : ~LRCLK_POLARITY;
        busy_d        = active_d;
        frame_start_d = active_d && (div_d == '0) && (bit_d == '0) && (slot_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            slot_q        <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= ~LRCLK_POLARITY;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            slot_q        <= slot_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign busy        = busy_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign frame_start = frame_start_q;
    assign slot        = slot_q;

`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Counts alongside the registered frame_start so both appear on the same mclk.
    always_comb begin
        frame_count_d = frame_count_q + 16'(frame_start_d);
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) frame_count_q <= 16'h0000;
        else     frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_i2s_tdm_clk_gen.sv
// Bench for i2s_tdm_clk_gen: default (TDM pulse) and I2S (NR=2, R=2, POL=0) instances against a frame-phase model.
// Covers the frame counter when I2S_TDM_CLKGEN_FRAME_COUNT_EN is defined.
module tb_i2s_tdm_clk_gen;

    localparam int NCFG = 2;

    logic mclk = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;

    logic       busy0, bclk0, lrclk0, fs0;
    logic [1:0] slot0;
    logic       busy1, bclk1, lrclk1, fs1;
    logic [0:0] slot1;
`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
    logic [15:0] fc0, fc1;
`endif

    int checks = 0;
    int errors = 0;

    // Per-config constants: [0] defaults, [1] I2S word clock.
    int c_nc   [NCFG] = '{4, 2};
    int c_sw   [NCFG] = '{32, 32};
    int c_r    [NCFG] = '{4, 2};
    int c_pol  [NCFG] = '{1, 0};
    int c_pulse[NCFG] = '{1, 0};

    // Model: running flag and mclk index within the current frame.
    bit m_run  [NCFG];
    int m_phase[NCFG];
    int m_fc   [NCFG];

    i2s_tdm_clk_gen dut0 (
        .mclk(mclk), .rst(rst), .en(en),
        .busy(busy0), .bclk(bclk0), .lrclk(lrclk0), .frame_start(fs0), .slot(slot0)
`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
        , .frame_count(fc0)
`endif
    );

    i2s_tdm_clk_gen #(
        .NR_CHANNELS(2), .SLOT_WIDTH(32), .MCLK_BCLK_RATIO(2),
        .LRCLK_POLARITY(1'b0), .FRAME_SYNC_PULSE(1'b0)
    ) dut1 (
        .mclk(mclk), .rst(rst), .en(en),
        .busy(busy1), .bclk(bclk1), .lrclk(lrclk1), .frame_start(fs1), .slot(slot1)
`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
        , .frame_count(fc1)
`endif
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            m_run[c]   = 1'b0;
            m_phase[c] = 0;
            m_fc[c]    = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCFG; c++) begin
            int frame_len;
            frame_len = c_nc[c] * c_sw[c] * c_r[c];
            if (rst) begin
                m_run[c] = 1'b0; m_phase[c] = 0; m_fc[c] = 0;
            end else if (!m_run[c]) begin
                if (en) begin m_run[c] = 1'b1; m_phase[c] = 0; end
            end else if (m_phase[c] == frame_len - 1) begin
                m_phase[c] = 0;
                if (!en) m_run[c] = 1'b0;
            end else begin
                m_phase[c]++;
            end
            if (!rst && m_run[c] && m_phase[c] == 0) m_fc[c] = (m_fc[c] + 1) % 65536;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int c = 0; c < NCFG; c++) begin
            int  div, bitpos, sl;
            bit  sync;
            logic [31:0] e_busy, e_bclk, e_lr, e_fs, e_slot;
            logic [31:0] o_busy, o_bclk, o_lr, o_fs, o_slot;
            div    = m_phase[c] % c_r[c];
            bitpos = (m_phase[c] / c_r[c]) % c_sw[c];
            sl     = m_phase[c] / (c_r[c] * c_sw[c]);
            sync   = c_pulse[c] ? (m_phase[c] < c_r[c]) : (sl < c_nc[c] / 2);
            e_busy = 32'(m_run[c]);
            e_bclk = 32'(m_run[c] && div >= c_r[c] / 2);
            e_lr   = (m_run[c] && sync) ? 32'(c_pol[c]) : 32'(1 - c_pol[c]);
            e_fs   = 32'(m_run[c] && m_phase[c] == 0);
            e_slot = m_run[c] ? 32'(sl) : 32'd0;
            if (bitpos < 0) e_slot = 32'hdead;
            o_busy = 32'(c == 0 ? busy0  : busy1);
            o_bclk = 32'(c == 0 ? bclk0  : bclk1);
            o_lr   = 32'(c == 0 ? lrclk0 : lrclk1);
            o_fs   = 32'(c == 0 ? fs0    : fs1);
            o_slot = (c == 0) ? 32'(slot0) : 32'(slot1);
            check($sformatf("%s_c%0d_busy", tag, c),  o_busy, e_busy);
            check($sformatf("%s_c%0d_bclk", tag, c),  o_bclk, e_bclk);
            check($sformatf("%s_c%0d_lrclk", tag, c), o_lr,   e_lr);
            check($sformatf("%s_c%0d_fs", tag, c),    o_fs,   e_fs);
            check($sformatf("%s_c%0d_slot", tag, c),  o_slot, e_slot);
`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
            check($sformatf("%s_c%0d_fc", tag, c), (c == 0) ? 32'(fc0) : 32'(fc1), 32'(m_fc[c]));
`endif
        end
    endtask

    // One mclk: model follows the edge, outputs compared on the falling edge.
    task automatic step(input string tag);
        @(posedge mclk);
        model_edge();
        @(negedge mclk);
        check_outputs(tag);
    endtask

    task automatic wait_frame_start(input string tag);
        int n;
        n = 0;
        while (fs0 !== 1'b1 && n < 2000) begin
            step(tag);
            n++;
        end
        check({tag, "_fs_seen"}, 32'(fs0 === 1'b1), 32'd1);
    endtask

    initial begin
        int k;
        model_reset();

        // Reset state.
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge mclk);
        check_outputs("reset");
        rst = 1'b0;
        repeat (3) step("idle");

        // en=1 -> frame_start and busy one mclk later, then exact 512-mclk frames.
        en = 1'b1;
        step("start");
        check("t1_fs_latency", 32'(fs0), 32'd1);
        check("t1_busy_latency", 32'(busy0), 32'd1);
        k = 0;
        do begin
            step("t1_run");
            k++;
        end while (fs0 !== 1'b1 && k < 1000);
        check("t1_frame_period", k, 512);

        // Stop mid-frame: frame completes, busy drops exactly 512 mclk after its frame_start.
        wait_frame_start("t3_sync");
        k = 0;
        repeat (200) begin step("t3_run"); k++; end
        en = 1'b0;
        while (busy0 === 1'b1 && k < 1000) begin step("t3_drain"); k++; end
        check("t3_drain_len", k, 512);
        repeat (40) step("t3_idle");

        // en 1->0->1 within one frame keeps the frame cadence.
        en = 1'b1;
        wait_frame_start("t4_sync");
        k = 0;
        repeat (100) begin step("t4_a"); k++; end
        en = 1'b0;
        repeat (50) begin step("t4_b"); k++; end
        en = 1'b1;
        while (fs0 !== 1'b1 && k < 1000) begin step("t4_c"); k++; end
        check("t4_no_gap", k, 512);

`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
        // Wrap from 0xFFFF to 0x0000 on the next frame_start.
        @(negedge mclk);
        force dut0.frame_count_q = 16'hFFFF;
        #1 release dut0.frame_count_q;
        m_fc[0] = 65535;
        @(negedge mclk);
        check("fc_forced", 32'(fc0), 32'h0000FFFF);
        wait_frame_start("fc_wrap");
        check("fc_wrapped", 32'(fc0), 32'h0);
`endif

        // Randomized en pattern.
        for (int seg = 0; seg < 24; seg++) begin
            en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 600)) step("rand");
        end

        // Asynchronous reset mid-slot 2: outputs reset before the next edge.
        en = 1'b1;
        k = 0;
        while (!(busy0 === 1'b1 && slot0 === 2'd2) && k < 2000) begin step("t6_seek"); k++; end
        check("t6_slot2_reached", 32'(slot0), 32'd2);
        repeat (10) step("t6_mid");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("t6_async_rst");
        @(negedge mclk);
        model_edge();
        check_outputs("t6_rst_held");
        rst = 1'b0;

`ifdef I2S_TDM_CLKGEN_FRAME_COUNT_EN
        // Three frames after reset -> frame_count = 3.
        repeat (1 + 3 * 512 - 1) step("fc_three");
        check("fc_three_frames", 32'(fc0), 32'd3);
`endif

        en = 1'b0;
        repeat (700) step("tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
